// File: rtl/instruction_encoder.sv
// RV32I instruction word encoder: packs opcode/register/funct fields and an immediate
// into one instruction word through a two-register valid/ready pipeline.
module instruction_encoder #(
  parameter int INSTRUCTION_BITSIZE = 32,
  parameter int OPCODE_SIZE         = 7,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OPCODE_SIZE-1:0]         opcode,
  input  logic [4:0]                     rd,
  input  logic [4:0]                     rs1,
  input  logic [4:0]                     rs2,
  input  logic [2:0]                     funct3,
  input  logic [6:0]                     funct7,
  input  logic [INSTRUCTION_BITSIZE-1:0] immediate,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INSTRUCTION_BITSIZE-1:0] instruction,
  output logic                           imm_error,
  output logic                           illegal_opcode,
  output logic [COUNT_WIDTH-1:0]         encoded_count
);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_t;

  logic                           s1_valid;
  logic [OPCODE_SIZE-1:0]         s1_opcode;
  logic [4:0]                     s1_rd;
  logic [4:0]                     s1_rs1;
  logic [4:0]                     s1_rs2;
  logic [2:0]                     s1_funct3;
  logic [6:0]                     s1_funct7;
  logic [INSTRUCTION_BITSIZE-1:0] s1_imm;

  logic                           s1_adv;
  fmt_t                           fmt;
  logic [INSTRUCTION_BITSIZE-1:0] enc;
  logic                           enc_imm_error;
  logic                           enc_illegal;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_imm    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_opcode <= opcode;
        s1_rd     <= rd;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_funct3 <= funct3;
        s1_funct7 <= funct7;
        s1_imm    <= immediate;
      end
    end
  end

  always_comb begin
    fmt = FMT_BAD;
    case (s1_opcode)
      7'b0110011:                         fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1101111:                         fmt = FMT_J;
      default:                            fmt = FMT_BAD;
    endcase
  end

  // Range violations still produce a word built from the truncated immediate bits.
  always_comb begin
    enc           = 32'h0000_0013;
    enc_imm_error = 1'b0;
    enc_illegal   = 1'b0;
    case (fmt)
      FMT_R: enc = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: begin
        enc           = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
        enc_imm_error = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      FMT_S: begin
        enc           = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
        enc_imm_error = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
      end
      FMT_B: begin
        enc           = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                         s1_imm[4:1], s1_imm[11], s1_opcode};
        enc_imm_error = s1_imm[0] || !((&s1_imm[31:12]) || !(|s1_imm[31:12]));
      end
      FMT_U: begin
        enc           = {s1_imm[31:12], s1_rd, s1_opcode};
        enc_imm_error = |s1_imm[11:0];
      end
      FMT_J: begin
        enc           = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
        enc_imm_error = s1_imm[0] || !((&s1_imm[31:20]) || !(|s1_imm[31:20]));
      end
      default: begin
        enc         = 32'h0000_0013;
        enc_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      instruction    <= '0;
      imm_error      <= 1'b0;
      illegal_opcode <= 1'b0;
    end else if (s1_adv) begin
      out_valid      <= 1'b1;
      instruction    <= enc;
      imm_error      <= enc_imm_error;
      illegal_opcode <= enc_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      encoded_count <= '0;
    end else if (out_valid && out_ready) begin
      encoded_count <= encoded_count + 1'b1;
    end
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the core's immediate decode path. Packs opcode, register fields, funct fields and a 32-bit signed immediate into one 32-bit RV32I instruction word.
- Used by the boot/program loader and by test program generators to build instruction memory images in hardware.
- Two-register valid/ready pipeline with backpressure, immediate range checking, illegal-opcode flagging and an output handshake counter.

Parameters:
INSTRUCTION_BITSIZE, 32, instruction and immediate width
OPCODE_SIZE, 7, opcode field width
COUNT_WIDTH, 16, width of encoded_count

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder accepts bundle this cycle
opcode  input  OPCODE_SIZE  target opcode
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R-type only)
immediate  input  INSTRUCTION_BITSIZE  signed byte-offset / value immediate
out_valid  output  1  instruction word valid
out_ready  input  1  consumer accepts word
instruction  output  INSTRUCTION_BITSIZE  encoded word
imm_error  output  1  immediate not representable; qualified by out_valid
illegal_opcode  output  1  opcode unsupported; qualified by out_valid
encoded_count  output  COUNT_WIDTH  number of completed output handshakes

Behaviour:
- Reset (synchronous, active-high):
  - s1_valid=0, out_valid=0, instruction=0, imm_error=0, illegal_opcode=0, encoded_count=0.
  - Any in-flight bundles are discarded with no output.
- Stage 1 (s1) registers the raw fields on input handshake (in_valid && in_ready).
- Encode logic is combinational from s1 into the stage 2 output register (instruction, flags, out_valid).
- Latency: handshake at edge N gives out_valid=1 after edge N+1.
- s1 advances when s1_valid && (!out_valid || out_ready).
- in_ready = !s1_valid || s1 advances. Sustained throughput is 1 word/cycle.
- While out_valid && !out_ready: instruction, imm_error and illegal_opcode hold stable. s1 holds its bundle. in_ready=0 once s1 is full.
- out_valid drops after an output handshake unless s1 advances in the same cycle.
- encoded_count increments on each out_valid && out_ready and wraps modulo 2^COUNT_WIDTH.
- Encoding by opcode (imm = immediate):
  - R 0110011: {funct7, rs2, rs1, funct3, rd, opcode}. imm ignored; imm_error=0.
  - I 0010011/0000011/1100111: {imm[11:0], rs1, funct3, rd, opcode}. Shift-immediates expect the caller to place funct7 bits in imm[11:5].
  - S 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U 0110111/0010111: {imm[31:12], rd, opcode}.
  - J 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Any other opcode: instruction=32'h00000013 (NOP), illegal_opcode=1, imm_error=0.
- imm_error rules (the word is still encoded from truncated bits):
  - I, S: imm[31:11] not all equal.
  - B: imm[0]=1, or imm[31:12] not all equal.
  - J: imm[0]=1, or imm[31:20] not all equal.
  - U: imm[11:0] not zero.
- Fields not used by a format are ignored.

Test Plan:
- ADDI: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> out_valid one cycle after handshake, instruction 0x00500093, both flags 0.
- SW and BEQ:
  - opcode 0100011, rs1=3, rs2=2, funct3=010, imm=-4 -> 0xFE21AE23.
  - opcode 1100011, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463.
- JAL and U-type:
  - opcode 1101111, rd=0, imm=-4 -> 0xFFDFF06F.
  - opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- Errors:
  - ADDI, rd=1, rs1=0, imm=0x800 -> 0x80000093, imm_error=1.
  - BEQ, imm=7 -> imm_error=1.
  - opcode 0x7F -> 0x00000013, illegal_opcode=1.
- Backpressure: out_ready=0, present 3 back-to-back bundles -> first held on output, second in s1, in_ready=0, third stalls. Raise out_ready -> 3 words in order on consecutive cycles, encoded_count=3.
- Reset mid-stream: assert reset with out_valid=1 and s1 full -> next cycle out_valid=0, encoded_count=0, in_ready=1, no stale word appears afterwards.
